// File: rtl/multi_cycle_adder.sv
`default_nettype none
// ============================================================================
// Module   : multi_cycle_adder
// Brief    : Adds two WIDTH-bit operands plus carry-in, CHUNK bits per clock.
//            Uses a valid/ready input handshake and a one-cycle done pulse.
//            Optional signed-overflow output: define MULTI_CYCLE_ADDER_OVERFLOW_EN.
// Revision : 1.0 - initial parametrised release
// ============================================================================
module multi_cycle_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             busy,
`ifdef MULTI_CYCLE_ADDER_OVERFLOW_EN
    output logic             overflow,
`endif
    output logic             done
);

    localparam int c_safe_chunk = (CHUNK < 1) ? 1 : CHUNK;
    localparam int c_num_chunks = WIDTH / c_safe_chunk;
    localparam int c_idx_w      = (c_num_chunks > 1) ? $clog2(c_num_chunks) : 1;
    localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(c_num_chunks - 1);

    generate
        if ((CHUNK < 1) || (CHUNK > WIDTH) || ((WIDTH % c_safe_chunk) != 0)) begin : g_bad_params
            $error("multi_cycle_adder: CHUNK must be in 1..WIDTH and divide WIDTH");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic                 w_accept;
    logic                 w_last;

    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;
    logic [WIDTH-1:0]     r_part;
    logic                 r_carry;
    logic [c_idx_w-1:0]   r_idx;

    logic [CHUNK-1:0]     w_a_chunk;
    logic [CHUNK-1:0]     w_b_chunk;
    logic [CHUNK:0]       w_chunk_sum;
    logic [WIDTH-1:0]     w_part_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        w_accept     = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                if (r_idx == c_last_idx) begin
                    w_last       = 1'b1;
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                done         = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Constant-index mux keeps the chunk select free of variable part-selects.
    always_comb begin
        w_a_chunk   = '0;
        w_b_chunk   = '0;
        w_part_next = r_part;
        for (int i = 0; i < c_num_chunks; i++) begin
            if (r_idx == c_idx_w'(i)) begin
                w_a_chunk = r_a[i*CHUNK +: CHUNK];
                w_b_chunk = r_b[i*CHUNK +: CHUNK];
            end
        end
        w_chunk_sum = {1'b0, w_a_chunk} + {1'b0, w_b_chunk} + {{CHUNK{1'b0}}, r_carry};
        for (int i = 0; i < c_num_chunks; i++) begin
            if (r_idx == c_idx_w'(i)) begin
                w_part_next[i*CHUNK +: CHUNK] = w_chunk_sum[CHUNK-1:0];
            end
        end
    end

`ifdef MULTI_CYCLE_ADDER_OVERFLOW_EN
    // Carry into the MSB recovered from the MSB's own sum bit and operands.
    logic w_msb_carry_in;
    assign w_msb_carry_in = w_a_chunk[CHUNK-1] ^ w_b_chunk[CHUNK-1] ^ w_chunk_sum[CHUNK-1];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_part   <= '0;
            r_carry  <= 1'b0;
            r_idx    <= '0;
            sum      <= '0;
            c_out    <= 1'b0;
`ifdef MULTI_CYCLE_ADDER_OVERFLOW_EN
            overflow <= 1'b0;
`endif
        end else if (w_accept) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= c_in;
            r_idx   <= '0;
            r_part  <= '0;
        end else if (r_state == ST_RUN) begin
            r_carry <= w_chunk_sum[CHUNK];
            r_part  <= w_part_next;
            r_idx   <= r_idx + c_idx_w'(1);
            // Result registers only change on the final chunk, so partial sums never show.
            if (w_last) begin
                sum      <= w_part_next;
                c_out    <= w_chunk_sum[CHUNK];
`ifdef MULTI_CYCLE_ADDER_OVERFLOW_EN
                overflow <= w_msb_carry_in ^ w_chunk_sum[CHUNK];
`endif
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_multi_cycle_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_multi_cycle_adder
// Brief    : Directed self-checking bench for multi_cycle_adder (N=4, 1, 16).
// Revision : 1.0 - initial release
// ============================================================================
module tb_multi_cycle_adder;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [15:0] a;
    logic [15:0] b;
    logic        c_in;

    logic        in_ready4, busy4, done4, c_out4;
    logic [15:0] sum4;
    logic        in_ready1, busy1, done1, c_out1;
    logic [15:0] sum1;
    logic        in_ready16, busy16, done16, c_out16;
    logic [15:0] sum16;
`ifdef MULTI_CYCLE_ADDER_OVERFLOW_EN
    logic        ov4, ov1, ov16;
`endif

    int n_checks = 0;
    int n_errors = 0;

    multi_cycle_adder #(.WIDTH(16), .CHUNK(4)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
        .a(a), .b(b), .c_in(c_in), .sum(sum4), .c_out(c_out4), .busy(busy4),
`ifdef MULTI_CYCLE_ADDER_OVERFLOW_EN
        .overflow(ov4),
`endif
        .done(done4)
    );

    multi_cycle_adder #(.WIDTH(16), .CHUNK(16)) u_dut_n1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
        .a(a), .b(b), .c_in(c_in), .sum(sum1), .c_out(c_out1), .busy(busy1),
`ifdef MULTI_CYCLE_ADDER_OVERFLOW_EN
        .overflow(ov1),
`endif
        .done(done1)
    );

    multi_cycle_adder #(.WIDTH(16), .CHUNK(1)) u_dut_n16 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready16),
        .a(a), .b(b), .c_in(c_in), .sum(sum16), .c_out(c_out16), .busy(busy16),
`ifdef MULTI_CYCLE_ADDER_OVERFLOW_EN
        .overflow(ov16),
`endif
        .done(done16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Called just after an edge with all DUTs idle; returns #1 after accept edge.
    task automatic accept(input logic [15:0] va, input logic [15:0] vb, input logic vc);
        in_valid = 1'b1;
        a        = va;
        b        = vb;
        c_in     = vc;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_done4(input string tag);
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (done4) break;
        end
        check(tag, done4, 1);
    endtask

    logic [15:0] va[8];
    logic [15:0] vb[8];
    logic        vc[8];

    initial begin
        int          nd;
        logic [16:0] exp_full;
        logic [15:0] s4, s16;
        logic        c4, c16, got4, got16;
`ifdef MULTI_CYCLE_ADDER_OVERFLOW_EN
        logic        o1, o4c, o16c, exp_ov;
`endif

        va[0] = 16'h7FFF; vb[0] = 16'h0001; vc[0] = 1'b0;
        va[1] = 16'h8000; vb[1] = 16'hFFFF; vc[1] = 1'b0;
        va[2] = 16'h0001; vb[2] = 16'h0001; vc[2] = 1'b0;
        va[3] = 16'hFFFF; vb[3] = 16'hFFFF; vc[3] = 1'b1;
        va[4] = 16'h0000; vb[4] = 16'h0000; vc[4] = 1'b0;
        va[5] = 16'hA5A5; vb[5] = 16'h5A5A; vc[5] = 1'b1;
        va[6] = 16'($urandom); vb[6] = 16'($urandom); vc[6] = 1'($urandom);
        va[7] = 16'($urandom); vb[7] = 16'($urandom); vc[7] = 1'($urandom);

        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; c_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_sum", sum4, 0);
        check("rst_c_out", c_out4, 0);
        check("rst_done", done4, 0);
        check("rst_busy", busy4, 0);
        check("rst_in_ready", in_ready4, 1);

        // Basic add and exact latency
        accept(16'h1234, 16'h4321, 1'b0);
        check("run_busy", busy4, 1);
        check("run_in_ready", in_ready4, 0);
        for (int k = 1; k < 4; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("run_busy_%0d", k), busy4, 1);
            check($sformatf("run_no_done_%0d", k), done4, 0);
        end
        @(posedge clk);
        #1;
        check("lat_done", done4, 1);
        check("lat_busy", busy4, 0);
        check("lat_in_ready", in_ready4, 0);
        check("basic_sum", sum4, 16'h5555);
        check("basic_c_out", c_out4, 0);
        @(posedge clk);
        #1;
        check("pulse_done", done4, 0);
        check("pulse_in_ready", in_ready4, 1);
        check("hold_sum", sum4, 16'h5555);

        // Carry ripple through all chunks
        accept(16'hFFFF, 16'h0001, 1'b0);
        wait_done4("ripple_done");
        check("ripple_sum", sum4, 16'h0000);
        check("ripple_c_out", c_out4, 1);
        @(posedge clk);
        #1;
        accept(16'hFFFF, 16'hFFFF, 1'b1);
        wait_done4("wrap_done");
        check("wrap_sum", sum4, 16'hFFFF);
        check("wrap_c_out", c_out4, 1);
        @(posedge clk);
        #1;

        // in_valid held during RUN must be ignored
        in_valid = 1'b1; a = 16'h00F0; b = 16'h000F; c_in = 1'b0;
        @(posedge clk);
        #1;
        a  = 16'h1111;
        nd = 0;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (done4) nd++;
        end
        check("busy_sum", sum4, 16'h00FF);
        in_valid = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (done4) nd++;
        end
        check("busy_single_done", nd, 1);
        accept(16'h1111, 16'h0000, 1'b0);
        wait_done4("second_done");
        check("second_sum", sum4, 16'h1111);
        @(posedge clk);
        #1;

        // Reset during the second RUN cycle
        accept(16'h1234, 16'h1111, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("mid_rst_busy", busy4, 0);
        check("mid_rst_in_ready", in_ready4, 1);
        check("mid_rst_sum", sum4, 0);
        check("mid_rst_c_out", c_out4, 0);
        check("mid_rst_done", done4, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        nd  = 0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (done4) nd++;
        end
        check("mid_rst_no_done", nd, 0);
        accept(16'h0003, 16'h0004, 1'b0);
        wait_done4("fresh_done");
        check("fresh_sum", sum4, 16'h0007);
        repeat (20) @(posedge clk);
        #1;

        // Sweep across N=1, N=4 and N=16
        for (int v = 0; v < 8; v++) begin
            exp_full = {1'b0, va[v]} + {1'b0, vb[v]} + {16'b0, vc[v]};
            accept(va[v], vb[v], vc[v]);
            @(posedge clk);
            #1;
            check($sformatf("n1_lat_%0d", v), done1, 1);
            check($sformatf("n1_sum_%0d", v), sum1, exp_full[15:0]);
            check($sformatf("n1_cout_%0d", v), c_out1, exp_full[16]);
`ifdef MULTI_CYCLE_ADDER_OVERFLOW_EN
            o1 = ov1;
`endif
            got4 = 1'b0; got16 = 1'b0;
            s4 = '0; s16 = '0; c4 = 1'b0; c16 = 1'b0;
`ifdef MULTI_CYCLE_ADDER_OVERFLOW_EN
            o4c = 1'b0; o16c = 1'b0;
`endif
            for (int k = 0; k < 30; k++) begin
                if (done4 && !got4) begin
                    got4 = 1'b1; s4 = sum4; c4 = c_out4;
`ifdef MULTI_CYCLE_ADDER_OVERFLOW_EN
                    o4c = ov4;
`endif
                end
                if (done16 && !got16) begin
                    got16 = 1'b1; s16 = sum16; c16 = c_out16;
`ifdef MULTI_CYCLE_ADDER_OVERFLOW_EN
                    o16c = ov16;
`endif
                end
                if (got4 && got16) break;
                @(posedge clk);
                #1;
            end
            check($sformatf("sweep_seen_%0d", v), {got4, got16}, 2'b11);
            check($sformatf("n4_sum_%0d", v), s4, exp_full[15:0]);
            check($sformatf("n4_cout_%0d", v), c4, exp_full[16]);
            check($sformatf("n16_sum_%0d", v), s16, exp_full[15:0]);
            check($sformatf("n16_cout_%0d", v), c16, exp_full[16]);
`ifdef MULTI_CYCLE_ADDER_OVERFLOW_EN
            exp_ov = (va[v][15] == vb[v][15]) && (exp_full[15] != va[v][15]);
            check($sformatf("n1_ovf_%0d", v), o1, exp_ov);
            check($sformatf("n4_ovf_%0d", v), o4c, exp_ov);
            check($sformatf("n16_ovf_%0d", v), o16c, exp_ov);
`endif
            repeat (2) @(posedge clk);
            #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
